// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results through and runs loads/stores against a
// variable-latency req/ack data memory, stalling upstream and aborting hung accesses.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ExValid,
  input  logic              ExRegWrite,
  input  logic              ExRegStore,
  input  logic              ExMemWrite,
  input  logic [DATA_W-1:0] ExALUResult,
  input  logic [DATA_W-1:0] ExStoreData,
  input  logic [RD_W-1:0]   ExRd,
  output logic              MemReq,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck,
  output logic              MemStall,
  output logic              MemErr,
  output logic              WBEnable,
  output logic              ORegWrite,
  output logic              ORegStore,
  output logic [DATA_W-1:0] OALUResult,
  output logic [DATA_W-1:0] OStoreMem,
  output logic [RD_W-1:0]   ORd
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t              state;
  logic                regwrite_p1;
  logic                regstore_p1;
  logic                memwrite_p1;
  logic [DATA_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [RD_W-1:0]     rd_p1;
  logic [DATA_W-1:0]   ldata_p2;
  logic [CNT_W-1:0]    cnt;
  logic                memop;

  assign memop = ExValid & (ExRegStore | ExMemWrite);

  // Stage 1: accept the memory op and hold it while the access is in flight
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state       <= IDLE;
      regwrite_p1 <= 1'b0;
      regstore_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      rd_p1       <= '0;
      ldata_p2    <= '0;
      cnt         <= '0;
      MemErr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            regwrite_p1 <= ExRegWrite;
            regstore_p1 <= ExRegStore;
            memwrite_p1 <= ExMemWrite;
            addr_p1     <= ExALUResult;
            wdata_p1    <= ExStoreData;
            rd_p1       <= ExRd;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        // Stage 2: wait for ack; an ack on the last allowed cycle still completes
        BUSY: begin
          if (MemAck) begin
            if (!memwrite_p1) ldata_p2 <= MemRData;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            MemErr <= 1'b1;
            state  <= ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 3: output decode toward MEM_WB, purely from registered state and EX_MEM inputs
  always_comb begin
    MemReq     = 1'b0;
    MemWE      = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    MemStall   = 1'b0;
    WBEnable   = 1'b0;
    ORegWrite  = 1'b0;
    ORegStore  = 1'b0;
    OALUResult = '0;
    OStoreMem  = '0;
    ORd        = '0;
    case (state)
      IDLE: begin
        if (memop) begin
          MemStall = 1'b1;
        end else if (ExValid) begin
          WBEnable   = 1'b1;
          ORegWrite  = ExRegWrite;
          ORegStore  = ExRegStore;
          OALUResult = ExALUResult;
          ORd        = ExRd;
        end
      end
      BUSY: begin
        MemReq   = 1'b1;
        MemWE    = memwrite_p1;
        MemAddr  = addr_p1;
        MemWData = wdata_p1;
        MemStall = 1'b1;
      end
      DONE: begin
        WBEnable   = 1'b1;
        ORegWrite  = regwrite_p1;
        ORegStore  = regstore_p1;
        OALUResult = addr_p1;
        ORd        = rd_p1;
        OStoreMem  = memwrite_p1 ? '0 : ldata_p2;
      end
      default: ;
    endcase
    // Reset held low abandons any access immediately, without waiting for the edge
    if (!Reset) begin
      MemReq   = 1'b0;
      MemStall = 1'b0;
      WBEnable = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized ops
// compared against a transaction-level model of the stage.
module tb_mem_access_stage;
  localparam int DATA_W  = 16;
  localparam int RD_W    = 3;
  localparam int TIMEOUT = 15;

  logic              CLK;
  logic              Reset;
  logic              ExValid, ExRegWrite, ExRegStore, ExMemWrite;
  logic [DATA_W-1:0] ExALUResult, ExStoreData;
  logic [RD_W-1:0]   ExRd;
  logic              MemReq, MemWE;
  logic [DATA_W-1:0] MemAddr, MemWData, MemRData;
  logic              MemAck, MemStall, MemErr, WBEnable;
  logic              ORegWrite, ORegStore;
  logic [DATA_W-1:0] OALUResult, OStoreMem;
  logic [RD_W-1:0]   ORd;

  int checks = 0;
  int errors = 0;
  bit model_err = 0;

  mem_access_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
    .ExRegStore(ExRegStore), .ExMemWrite(ExMemWrite), .ExALUResult(ExALUResult),
    .ExStoreData(ExStoreData), .ExRd(ExRd), .MemReq(MemReq), .MemWE(MemWE),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .MemStall(MemStall), .MemErr(MemErr), .WBEnable(WBEnable), .ORegWrite(ORegWrite),
    .ORegStore(ORegStore), .OALUResult(OALUResult), .OStoreMem(OStoreMem), .ORd(ORd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input bit req, input bit stall, input bit wb);
    chk({tag, ".MemReq"}, 32'(MemReq), 32'(req));
    chk({tag, ".MemStall"}, 32'(MemStall), 32'(stall));
    chk({tag, ".WBEnable"}, 32'(WBEnable), 32'(wb));
    chk({tag, ".MemErr"}, 32'(MemErr), 32'(model_err));
  endtask

  task automatic junk_ex();
    ExValid     = 1'($urandom);
    ExRegWrite  = 1'($urandom);
    ExRegStore  = 1'($urandom);
    ExMemWrite  = 1'($urandom);
    ExALUResult = DATA_W'($urandom);
    ExStoreData = DATA_W'($urandom);
    ExRd        = RD_W'($urandom);
  endtask

  // ALU-only instruction: written back in the same cycle with no stall
  task automatic alu_op(input bit rw, input logic [DATA_W-1:0] alu, input logic [RD_W-1:0] rd);
    ExValid = 1; ExRegWrite = rw; ExRegStore = 0; ExMemWrite = 0;
    ExALUResult = alu; ExStoreData = DATA_W'($urandom); ExRd = rd;
    MemAck = 1'($urandom);
    #1;
    chk_ctl("alu", 0, 0, 1);
    chk("alu.ORegWrite", 32'(ORegWrite), 32'(rw));
    chk("alu.ORegStore", 32'(ORegStore), 0);
    chk("alu.OALUResult", 32'(OALUResult), 32'(alu));
    chk("alu.ORd", 32'(ORd), 32'(rd));
    chk("alu.OStoreMem", 32'(OStoreMem), 0);
    @(negedge CLK);
  endtask

  // Memory op; k = BUSY cycle (1-based) carrying the ack, 0 = never acked
  task automatic mem_op(input bit wr, input bit rs, input bit rw,
                        input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input logic [RD_W-1:0] rd, input int k, input logic [DATA_W-1:0] rdata);
    int nb;
    ExValid = 1; ExRegWrite = rw; ExRegStore = rs; ExMemWrite = wr;
    ExALUResult = addr; ExStoreData = wdata; ExRd = rd; MemAck = 0;
    #1;
    chk_ctl("accept", 0, 1, 0);
    @(negedge CLK);
    nb = (k == 0) ? TIMEOUT : k;
    for (int j = 1; j <= nb; j++) begin
      junk_ex();
      MemAck   = (j == k);
      MemRData = (j == k) ? rdata : DATA_W'($urandom);
      #1;
      chk_ctl("busy", 1, 1, 0);
      chk("busy.MemWE", 32'(MemWE), 32'(wr));
      chk("busy.MemAddr", 32'(MemAddr), 32'(addr));
      chk("busy.MemWData", 32'(MemWData), 32'(wdata));
      @(negedge CLK);
    end
    junk_ex();
    MemAck = 1'($urandom);
    MemRData = DATA_W'($urandom);
    #1;
    if (k != 0) begin
      chk_ctl("done", 0, 0, 1);
      chk("done.ORegWrite", 32'(ORegWrite), 32'(rw));
      chk("done.ORegStore", 32'(ORegStore), 32'(rs));
      chk("done.OALUResult", 32'(OALUResult), 32'(addr));
      chk("done.ORd", 32'(ORd), 32'(rd));
      chk("done.OStoreMem", 32'(OStoreMem), wr ? 32'd0 : 32'(rdata));
    end else begin
      model_err = 1;
      chk_ctl("err", 0, 0, 0);
    end
    @(negedge CLK);
  endtask

  task automatic idle_cycle();
    ExValid = 0; ExRegWrite = 1'($urandom); ExRegStore = 1'($urandom);
    ExMemWrite = 1'($urandom); ExALUResult = DATA_W'($urandom);
    MemAck = 1'($urandom);
    #1;
    chk_ctl("idle", 0, 0, 0);
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_ctl(tag, 0, 0, 0);
    chk({tag, ".MemWE"}, 32'(MemWE), 0);
    chk({tag, ".MemAddr"}, 32'(MemAddr), 0);
    chk({tag, ".MemWData"}, 32'(MemWData), 0);
    chk({tag, ".ORegWrite"}, 32'(ORegWrite), 0);
    chk({tag, ".ORegStore"}, 32'(ORegStore), 0);
    chk({tag, ".OALUResult"}, 32'(OALUResult), 0);
    chk({tag, ".OStoreMem"}, 32'(OStoreMem), 0);
    chk({tag, ".ORd"}, 32'(ORd), 0);
  endtask

  initial begin
    Reset = 0; ExValid = 0; ExRegWrite = 0; ExRegStore = 0; ExMemWrite = 0;
    ExALUResult = '0; ExStoreData = '0; ExRd = '0; MemRData = '0; MemAck = 0;
    @(negedge CLK); @(negedge CLK);
    #1;
    chk_all_zero("reset");
    ExValid = 1; ExRegWrite = 1; ExALUResult = 16'h7777;
    #1;
    chk("reset.WBforced", 32'(WBEnable), 0);
    @(negedge CLK);
    Reset = 1;

    alu_op(1, 16'h1234, 3'd5);                                  // 1: ALU pass-through
    mem_op(0, 1, 1, 16'h0040, 16'h0000, 3'd2, 2, 16'hBEEF);     // 2: load, 2 BUSY cycles
    mem_op(1, 0, 0, 16'h0010, 16'hA5A5, 3'd0, 1, 16'h0000);     // 3: store, first-cycle ack
    idle_cycle();
    mem_op(0, 1, 1, 16'h0123, 16'h0000, 3'd6, TIMEOUT, 16'hC0DE); // 5: ack at last count
    mem_op(1, 1, 1, 16'h0200, 16'h5A5A, 3'd7, 3, 16'hFFFF);     // store forwarding RegWrite
    mem_op(0, 1, 1, 16'h0300, 16'h0000, 3'd1, 0, 16'h0000);     // 4: timeout
    alu_op(1, 16'h4321, 3'd3);
    idle_cycle();
    mem_op(0, 1, 0, 16'h0044, 16'h0000, 3'd4, 1, 16'h1357);     // MemErr remains set

    for (int n = 0; n < 40; n++) begin
      int sel;
      bit wr, rs;
      sel = int'($urandom_range(0, 9));
      if (sel < 3) alu_op(1'($urandom), DATA_W'($urandom), RD_W'($urandom));
      else if (sel == 3) idle_cycle();
      else begin
        wr = 1'($urandom);
        rs = wr ? 1'($urandom) : 1'b1;
        mem_op(wr, rs, 1'($urandom), DATA_W'($urandom), DATA_W'($urandom), RD_W'($urandom),
               (sel == 9) ? 0 : int'($urandom_range(1, TIMEOUT)), DATA_W'($urandom));
      end
    end

    // 6: reset asserted mid-access
    ExValid = 1; ExRegWrite = 1; ExRegStore = 1; ExMemWrite = 0;
    ExALUResult = 16'h0abc; ExStoreData = '0; ExRd = 3'd1; MemAck = 0;
    @(negedge CLK);
    junk_ex();
    #1;
    chk("rst6.busyReq", 32'(MemReq), 1);
    @(negedge CLK);
    Reset = 0;
    #1;
    chk("rst6.MemReq", 32'(MemReq), 0);
    chk("rst6.MemStall", 32'(MemStall), 0);
    chk("rst6.WBEnable", 32'(WBEnable), 0);
    @(negedge CLK);
    Reset = 1; model_err = 0;
    ExValid = 0; ExRegWrite = 0; ExRegStore = 0; ExMemWrite = 0;
    ExALUResult = '0; ExStoreData = '0; ExRd = '0; MemAck = 1; MemRData = 16'hDEAD;
    #1;
    chk_all_zero("rst6.post");
    @(negedge CLK);
    #1;
    chk_all_zero("rst6.stray");
    @(negedge CLK);
    alu_op(0, 16'h0F0F, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
